// File: rtl/test_sequencer_pkg.sv
// Shared constants for the test sequencer: default widths, the ROM address
// width alias, 3-bit state encodings and the wait-counter load helper.
package test_sequencer_pkg;

   localparam int TEST_I_ADDR_WIDTH = 5;
   localparam int TEST_NUM_TESTS    = 32;
   localparam int TEST_STIM_WIDTH   = 16;
   localparam int TEST_RESP_WIDTH   = 8;
   localparam int TEST_LATENCY      = 2;
   localparam int TEST_LAT_WIDTH    = 4;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_DRIVE = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_CHECK = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_FETCH = ST_FETCH,
      S_DRIVE = ST_DRIVE,
      S_WAIT  = ST_WAIT,
      S_CHECK = ST_CHECK,
      S_DONE  = ST_DONE
   } seq_state_t;

   // WAIT lasts LATENCY cycles, so the down-counter starts at LATENCY-1.
   // A zero latency skips WAIT entirely; load 0 so nothing wraps.
   function automatic logic [TEST_LAT_WIDTH-1:0] wait_load(input int lat);
      if (lat > 0)
         return TEST_LAT_WIDTH'(lat - 1);
      else
         return '0;
   endfunction

endpackage

// File: rtl/test_sequencer_resp_cmp.sv
// Masked response comparator: match is high when every bit selected by
// mask agrees between the DUT response and the expected value.
module test_resp_cmp
   import test_sequencer_pkg::*;
#(
   parameter int RESP_WIDTH = TEST_RESP_WIDTH
) (
   input  logic [RESP_WIDTH-1:0] resp,
   input  logic [RESP_WIDTH-1:0] expected,
   input  logic [RESP_WIDTH-1:0] mask,
   output logic                  match
);

   logic [RESP_WIDTH-1:0] w_diff;

   assign w_diff = (resp ^ expected) & mask;
   assign match  = ~|w_diff;

endmodule

// File: rtl/test_sequencer.sv
// Test sequencer: walks a synchronous test ROM, drives each stimulus into
// the unit under test, waits a fixed response latency and does a masked
// compare, accumulating pass/fail counts and the first failing index.
// Optional build macro: TEST_SEQ_STOP_ON_FAIL_EN ends the run at the first
// failing check instead of running every test.
//
// state | meaning
// IDLE  | after reset, waiting for start
// FETCH | rom_addr presented, ROM read in flight
// DRIVE | ROM data valid; stimulus strobed to DUT, expected/mask latched
// WAIT  | response latency down-counter running
// CHECK | masked compare, counters updated
// DONE  | run finished, done/result held until the next start
module test_sequencer
   import test_sequencer_pkg::*;
#(
   parameter int ADDR_WIDTH = TEST_I_ADDR_WIDTH,
   parameter int NUM_TESTS  = TEST_NUM_TESTS,
   parameter int STIM_WIDTH = TEST_STIM_WIDTH,
   parameter int RESP_WIDTH = TEST_RESP_WIDTH,
   parameter int LATENCY    = TEST_LATENCY
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [STIM_WIDTH-1:0] rom_stim,
   input  logic [RESP_WIDTH-1:0] rom_expected,
   input  logic [RESP_WIDTH-1:0] rom_mask,
   output logic [STIM_WIDTH-1:0] dut_stim,
   output logic                  dut_valid,
   input  logic [RESP_WIDTH-1:0] dut_resp,
   output logic [ADDR_WIDTH-1:0] test,
   output logic                  busy,
   output logic                  done,
   output logic                  result,
   output logic [ADDR_WIDTH:0]   pass_count,
   output logic [ADDR_WIDTH:0]   fail_count,
   output logic [ADDR_WIDTH-1:0] first_fail
);

   localparam logic [ADDR_WIDTH-1:0]     LAST_TEST = ADDR_WIDTH'(NUM_TESTS - 1);
   localparam logic [TEST_LAT_WIDTH-1:0] WAIT_INIT = wait_load(LATENCY);
   localparam logic                      HAS_WAIT  = (LATENCY > 0);

   seq_state_t r_state;
   seq_state_t w_state_next;

   logic [ADDR_WIDTH-1:0]     r_test;
   logic [STIM_WIDTH-1:0]     r_dut_stim;
   logic [RESP_WIDTH-1:0]     r_expected;
   logic [RESP_WIDTH-1:0]     r_mask;
   logic [TEST_LAT_WIDTH-1:0] r_wait_cnt;
   logic [ADDR_WIDTH:0]       r_pass_count;
   logic [ADDR_WIDTH:0]       r_fail_count;
   logic [ADDR_WIDTH-1:0]     r_first_fail;
   logic                      r_done;
   logic                      r_result;

   logic w_match;
   logic w_last;
   logic w_stop;
   logic w_clear;

   test_resp_cmp #(
      .RESP_WIDTH (RESP_WIDTH)
   ) u_resp_cmp (
      .resp     (dut_resp),
      .expected (r_expected),
      .mask     (r_mask),
      .match    (w_match)
   );

   assign w_last = (r_test == LAST_TEST);

`ifdef TEST_SEQ_STOP_ON_FAIL_EN
   assign w_stop = ~w_match;
`else
   assign w_stop = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   // Next-state decode; w_clear marks an accepted start.
   always_comb begin
      w_state_next = r_state;
      w_clear      = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_next = S_FETCH;
               w_clear      = 1'b1;
            end
         end
         S_FETCH: w_state_next = S_DRIVE;
         S_DRIVE: w_state_next = HAS_WAIT ? S_WAIT : S_CHECK;
         S_WAIT: begin
            if (r_wait_cnt == '0)
               w_state_next = S_CHECK;
         end
         S_CHECK: begin
            if (w_last || w_stop)
               w_state_next = S_DONE;
            else
               w_state_next = S_FETCH;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Datapath: stimulus/expected capture, latency timer, result counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_test       <= '0;
         r_dut_stim   <= '0;
         r_expected   <= '0;
         r_mask       <= '0;
         r_wait_cnt   <= '0;
         r_pass_count <= '0;
         r_fail_count <= '0;
         r_first_fail <= '0;
         r_done       <= 1'b0;
         r_result     <= 1'b0;
      end else begin
         if (w_clear) begin
            r_test       <= '0;
            r_pass_count <= '0;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_done       <= 1'b0;
            r_result     <= 1'b0;
         end

         if (r_state == S_DRIVE) begin
            r_dut_stim <= rom_stim;
            r_expected <= rom_expected;
            r_mask     <= rom_mask;
            r_wait_cnt <= WAIT_INIT;
         end

         if (r_state == S_WAIT && r_wait_cnt != '0)
            r_wait_cnt <= r_wait_cnt - TEST_LAT_WIDTH'(1);

         if (r_state == S_CHECK) begin
            if (w_match) begin
               r_pass_count <= r_pass_count + (ADDR_WIDTH+1)'(1);
            end else begin
               r_fail_count <= r_fail_count + (ADDR_WIDTH+1)'(1);
               if (r_fail_count == '0)
                  r_first_fail <= r_test;
            end

            if (w_state_next == S_DONE) begin
               r_done   <= 1'b1;
               // Final fail count is zero only if none so far and this one passes.
               r_result <= w_match && (r_fail_count == '0);
            end else begin
               r_test <= r_test + ADDR_WIDTH'(1);
            end
         end
      end
   end

   // During DRIVE the ROM word goes straight out so it is valid alongside
   // dut_valid; the registered copy holds it through WAIT and CHECK.
   assign dut_stim   = (r_state == S_DRIVE) ? rom_stim : r_dut_stim;
   assign dut_valid  = (r_state == S_DRIVE);
   assign rom_addr   = r_test;
   assign test       = r_test;
   assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done       = r_done;
   assign result     = r_result;
   assign pass_count = r_pass_count;
   assign fail_count = r_fail_count;
   assign first_fail = r_first_fail;

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: a synchronous ROM model and a combinational
// unit-under-test model feed the sequencer; expected counts come from a
// table-walking reference model. A second instance covers LATENCY=0 with
// a single test.
module tb_test_sequencer;

   localparam int AW  = 5;
   localparam int N   = 32;
   localparam int SW  = 16;
   localparam int RW  = 8;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          start_z;
   logic [AW-1:0] rom_addr, test, first_fail;
   logic [SW-1:0] rom_stim, dut_stim;
   logic [RW-1:0] rom_expected, rom_mask, dut_resp;
   logic          dut_valid, busy, done, result;
   logic [AW:0]   pass_count, fail_count;

   logic [AW-1:0] rom_addr_z, test_z, first_fail_z;
   logic [SW-1:0] rom_stim_z, dut_stim_z;
   logic [RW-1:0] rom_expected_z, rom_mask_z, dut_resp_z;
   logic          dut_valid_z, busy_z, done_z, result_z;
   logic [AW:0]   pass_count_z, fail_count_z;

   logic [SW-1:0] m_stim [N];
   logic [RW-1:0] m_exp  [N];
   logic [RW-1:0] m_mask [N];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [RW-1:0] dut_fn(input logic [SW-1:0] s);
      return s[7:0] ^ {s[11:8], s[15:12]} ^ 8'h5A;
   endfunction

   always @(posedge clk) begin
      rom_stim       <= m_stim[rom_addr];
      rom_expected   <= m_exp[rom_addr];
      rom_mask       <= m_mask[rom_addr];
      rom_stim_z     <= m_stim[rom_addr_z];
      rom_expected_z <= m_exp[rom_addr_z];
      rom_mask_z     <= m_mask[rom_addr_z];
   end

   assign dut_resp   = dut_fn(dut_stim);
   assign dut_resp_z = dut_fn(dut_stim_z);

   wire [46:0] all_out   = {rom_addr, dut_stim, dut_valid, test, busy, done, result,
                            pass_count, fail_count, first_fail};
   wire [46:0] all_out_z = {rom_addr_z, dut_stim_z, dut_valid_z, test_z, busy_z, done_z,
                            result_z, pass_count_z, fail_count_z, first_fail_z};

   test_sequencer #(.ADDR_WIDTH(AW), .NUM_TESTS(N), .STIM_WIDTH(SW),
                    .RESP_WIDTH(RW), .LATENCY(LAT)) u_dut (
      .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr),
      .rom_stim(rom_stim), .rom_expected(rom_expected), .rom_mask(rom_mask),
      .dut_stim(dut_stim), .dut_valid(dut_valid), .dut_resp(dut_resp),
      .test(test), .busy(busy), .done(done), .result(result),
      .pass_count(pass_count), .fail_count(fail_count), .first_fail(first_fail));

   test_sequencer #(.ADDR_WIDTH(AW), .NUM_TESTS(1), .STIM_WIDTH(SW),
                    .RESP_WIDTH(RW), .LATENCY(0)) u_dut_z (
      .clk(clk), .reset(reset), .start(start_z), .rom_addr(rom_addr_z),
      .rom_stim(rom_stim_z), .rom_expected(rom_expected_z), .rom_mask(rom_mask_z),
      .dut_stim(dut_stim_z), .dut_valid(dut_valid_z), .dut_resp(dut_resp_z),
      .test(test_z), .busy(busy_z), .done(done_z), .result(result_z),
      .pass_count(pass_count_z), .fail_count(fail_count_z), .first_fail(first_fail_z));

   task automatic fill_matching();
      for (int i = 0; i < N; i++) begin
         m_stim[i] = SW'($urandom);
         m_exp[i]  = dut_fn(m_stim[i]);
         m_mask[i] = 8'hFF;
      end
   endtask

   // Walk the test table: a test passes when every masked bit of the
   // response agrees with the expected value.
   task automatic model(output int e_pass, output int e_fail, output int e_ff,
                        output int e_test, output int e_cyc);
      e_pass = 0; e_fail = 0; e_ff = 0; e_test = N - 1;
      for (int i = 0; i < N; i++) begin
         if (((dut_fn(m_stim[i]) ^ m_exp[i]) & m_mask[i]) == 8'h00) begin
            e_pass++;
         end else begin
            if (e_fail == 0) e_ff = i;
            e_fail++;
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
            e_test = i;
            break;
`endif
         end
      end
      e_cyc = (e_test + 1) * (LAT + 3);
   endtask

   // Start a run and measure it; optionally pulse start again mid-run.
   task automatic run_once(input int inject_at, output int cyc, output int pulses,
                           output int stim_bad, output logic busy0);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      busy0 = busy; cyc = 0; pulses = 0; stim_bad = 0;
      while (done !== 1'b1 && cyc < 2000) begin
         start = (cyc == inject_at);
         @(posedge clk); #1;
         cyc++;
         if (dut_valid === 1'b1) begin
            pulses++;
            if (dut_stim !== m_stim[test]) stim_bad++;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; start_z = 1'b0;
      fill_matching();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_out); end
      checks++; if (all_out_z !== '0) begin errors++; $display("FAIL reset_outputs_z: got %h want 0", all_out_z); end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_all_match();
      int cyc, pulses, bad, ep, ef, eff, et, ec;
      logic b0;
      fill_matching();
      model(ep, ef, eff, et, ec);
      run_once(-1, cyc, pulses, bad, b0);
      checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL all_busy_rise: got %b want 1", b0); end
      checks++; if (cyc != 160) begin errors++; $display("FAIL all_cycles: got %0d want 160", cyc); end
      checks++; if (pulses != N) begin errors++; $display("FAIL all_pulses: got %0d want %0d", pulses, N); end
      checks++; if (bad != 0) begin errors++; $display("FAIL all_stim: got %0d bad want 0", bad); end
      checks++; if (pass_count !== 6'(ep) || ep != 32) begin errors++; $display("FAIL all_pass: got %0d want 32", pass_count); end
      checks++; if (fail_count !== 6'd0) begin errors++; $display("FAIL all_fail: got %0d want 0", fail_count); end
      checks++; if (result !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL all_result: got result %b busy %b want 1 0", result, busy); end
      checks++; if (test !== 5'(N - 1)) begin errors++; $display("FAIL all_test: got %0d want %0d", test, N - 1); end
   endtask

   task automatic test_corrupt();
      int cyc, pulses, bad, ep, ef, eff, et, ec;
      logic b0;
      fill_matching();
      m_exp[5] = m_exp[5] ^ 8'h01;
      m_exp[9] = m_exp[9] ^ 8'h01;
      model(ep, ef, eff, et, ec);
      run_once(-1, cyc, pulses, bad, b0);
      checks++; if (pass_count !== 6'(ep)) begin errors++; $display("FAIL corrupt_pass: got %0d want %0d", pass_count, ep); end
      checks++; if (fail_count !== 6'(ef)) begin errors++; $display("FAIL corrupt_fail: got %0d want %0d", fail_count, ef); end
      checks++; if (first_fail !== 5'd5) begin errors++; $display("FAIL corrupt_first: got %0d want 5", first_fail); end
      checks++; if (result !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL corrupt_result: got result %b done %b want 0 1", result, done); end
      checks++; if (test !== 5'(et) || cyc != ec) begin errors++; $display("FAIL corrupt_end: got test %0d cyc %0d want %0d %0d", test, cyc, et, ec); end
   endtask

   task automatic test_masked_corrupt();
      int cyc, pulses, bad, ep, ef, eff, et, ec;
      logic b0;
      fill_matching();
      m_exp[5] = m_exp[5] ^ 8'h01;  m_mask[5] = 8'hFE;
      m_exp[9] = m_exp[9] ^ 8'h01;  m_mask[9] = 8'hFE;
      m_exp[12] = ~m_exp[12];       m_mask[12] = 8'h00;
      model(ep, ef, eff, et, ec);
      run_once(-1, cyc, pulses, bad, b0);
      checks++; if (result !== 1'b1) begin errors++; $display("FAIL masked_result: got %b want 1", result); end
      checks++; if (pass_count !== 6'd32 || ep != 32) begin errors++; $display("FAIL masked_pass: got %0d want 32", pass_count); end
      checks++; if (first_fail !== 5'd0) begin errors++; $display("FAIL masked_first: got %0d want 0", first_fail); end
   endtask

   task automatic test_random();
      int cyc, pulses, bad, ep, ef, eff, et, ec;
      logic b0;
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N; i++) begin
            m_stim[i] = SW'($urandom);
            m_exp[i]  = dut_fn(m_stim[i]) ^ (($urandom_range(0, 3) == 0) ? RW'($urandom) : 8'h00);
            m_mask[i] = ($urandom_range(0, 4) == 0) ? 8'h00 : RW'($urandom) | 8'h81;
         end
         model(ep, ef, eff, et, ec);
         run_once(-1, cyc, pulses, bad, b0);
         checks++;
         if (pass_count !== 6'(ep) || fail_count !== 6'(ef) || first_fail !== 5'(eff)) begin
            errors++;
            $display("FAIL random_counts[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", r,
                     pass_count, fail_count, first_fail, ep, ef, eff);
         end
         checks++;
         if (result !== (ef == 0) || test !== 5'(et) || cyc != ec || pulses != et + 1 || bad != 0) begin
            errors++;
            $display("FAIL random_run[%0d]: got res %b test %0d cyc %0d pulses %0d bad %0d want %b %0d %0d %0d 0",
                     r, result, test, cyc, pulses, bad, ef == 0, et, ec, et + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc, pulses, bad, ep, ef, eff, et, ec;
      logic b0;
      fill_matching();
      m_exp[3]  = m_exp[3] ^ 8'h40;
      m_exp[20] = m_exp[20] ^ 8'h02;
      model(ep, ef, eff, et, ec);
      run_once(7, cyc, pulses, bad, b0);
      checks++;
      if (cyc != ec || pass_count !== 6'(ep) || fail_count !== 6'(ef) || first_fail !== 5'(eff)) begin
         errors++;
         $display("FAIL ignore_start: got cyc %0d %0d/%0d/%0d want %0d %0d/%0d/%0d",
                  cyc, pass_count, fail_count, first_fail, ec, ep, ef, eff);
      end
      run_once(-1, cyc, pulses, bad, b0);
      checks++;
      if (cyc != ec || pass_count !== 6'(ep) || fail_count !== 6'(ef) || first_fail !== 5'(eff) || result !== (ef == 0)) begin
         errors++;
         $display("FAIL restart_done: got cyc %0d %0d/%0d/%0d want %0d %0d/%0d/%0d",
                  cyc, pass_count, fail_count, first_fail, ec, ep, ef, eff);
      end
   endtask

   task automatic test_reset_mid_run();
      int cyc, pulses, bad, ep, ef, eff, et, ec, n;
      logic b0;
      fill_matching();
      model(ep, ef, eff, et, ec);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      n = 0;
      while (!(dut_valid === 1'b1 && test === 5'd10) && n < 1000) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n >= 1000) begin
         errors++; $display("FAIL midreset_reach: got timeout want test 10 drive");
      end else begin
         @(posedge clk); #2;
         reset = 1'b1;
         #1;
         checks++; if (all_out !== '0) begin errors++; $display("FAIL midreset_outputs: got %h want 0", all_out); end
         @(negedge clk); reset = 1'b0;
         @(posedge clk); #1;
         checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_idle: got busy %b done %b want 0 0", busy, done); end
      end
      run_once(-1, cyc, pulses, bad, b0);
      checks++;
      if (cyc != 160 || pass_count !== 6'd32 || fail_count !== 6'd0 || result !== 1'b1) begin
         errors++;
         $display("FAIL midreset_rerun: got cyc %0d pass %0d fail %0d res %b want 160 32 0 1",
                  cyc, pass_count, fail_count, result);
      end
   endtask

   task automatic test_lat0_single();
      int cyc, pulses;
      for (int k = 0; k < 2; k++) begin
         fill_matching();
         if (k == 1) m_exp[0] = m_exp[0] ^ 8'h80;
         @(negedge clk); start_z = 1'b1;
         @(posedge clk); #1; start_z = 1'b0;
         cyc = 0; pulses = 0;
         while (done_z !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
            if (dut_valid_z === 1'b1) pulses++;
         end
         checks++;
         if (cyc != 3 || pulses != 1 || test_z !== 5'd0) begin
            errors++;
            $display("FAIL lat0_timing[%0d]: got cyc %0d pulses %0d test %0d want 3 1 0", k, cyc, pulses, test_z);
         end
         checks++;
         if (pass_count_z !== 6'(1 - k) || fail_count_z !== 6'(k) || result_z !== (k == 0)) begin
            errors++;
            $display("FAIL lat0_result[%0d]: got %0d/%0d res %b want %0d/%0d res %b", k,
                     pass_count_z, fail_count_z, result_z, 1 - k, k, k == 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_all_match();
      test_corrupt();
      test_masked_corrupt();
      test_random();
      test_back_to_back();
      test_reset_mid_run();
      test_lat0_single();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
